// File: rtl/puf_race_controller.sv
// Delay-PUF race sequencer: per response bit, settle the muxes, race two counters, record the winner.
// Optional PUF_MAJORITY_VOTE_EN: three races per bit, response bit is the 2-of-3 majority.
module puf_race_controller #(
  parameter int RESP_BITS     = 8,
  parameter int SEL_W         = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter int TIMEOUT       = 1023
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [RESP_BITS*2*SEL_W-1:0] challenge,
  input  logic                         finished_a,
  input  logic                         finished_b,
  output logic [SEL_W-1:0]             sel_a,
  output logic [SEL_W-1:0]             sel_b,
  output logic                         cnt_reset,
  output logic                         cnt_enable,
  output logic                         busy,
  output logic                         done,
  output logic [RESP_BITS-1:0]         response,
  output logic                         error
);

  localparam int IDX_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam int ST_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RESP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_RACE, S_RECORD, S_DONE
  } state_t;

  state_t state, state_d;

  // challenge viewed as [bit][a/b][select]
  logic [RESP_BITS-1:0][1:0][SEL_W-1:0] chal_q;
  logic [IDX_W-1:0] idx;
  logic [ST_W-1:0]  settle_cnt;
  logic [TO_W-1:0]  race_cnt;
  logic             bit_q;
  logic             last_pass;
  logic             settle_end;
  logic             race_end;
  logic             pulse;

`ifdef PUF_MAJORITY_VOTE_EN
  logic [1:0] pass_q;
  logic [1:0] vote_q;
  assign last_pass = (pass_q == 2'd2);
`else
  assign last_pass = 1'b1;
`endif

  assign pulse      = finished_a | finished_b;
  assign settle_end = (settle_cnt == ST_W'(SETTLE_CYCLES - 1));
  assign race_end   = pulse || (race_cnt == TO_W'(TIMEOUT - 1));

  // Selects stay on the current slice through SELECT/RACE/RECORD so the race sees stable muxes.
  assign sel_a = busy ? chal_q[idx][0] : '0;
  assign sel_b = busy ? chal_q[idx][1] : '0;

  always_comb begin
    state_d    = state;
    cnt_reset  = 1'b0;
    cnt_enable = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_d = S_SELECT;
      end
      S_SELECT: begin
        busy      = 1'b1;
        cnt_reset = 1'b1;
        if (settle_end) state_d = S_RACE;
      end
      S_RACE: begin
        busy       = 1'b1;
        cnt_enable = 1'b1;
        if (race_end) state_d = S_RECORD;
      end
      S_RECORD: begin
        busy = 1'b1;
        if (last_pass && idx == LAST_IDX) state_d = S_DONE;
        else                              state_d = S_SELECT;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      chal_q     <= '0;
      idx        <= '0;
      settle_cnt <= '0;
      race_cnt   <= '0;
      bit_q      <= 1'b0;
      response   <= '0;
      error      <= 1'b0;
`ifdef PUF_MAJORITY_VOTE_EN
      pass_q     <= '0;
      vote_q     <= '0;
`endif
    end else begin
      state <= state_d;
      case (state)
        S_IDLE: begin
          if (start) begin
            chal_q     <= challenge;
            response   <= '0;
            error      <= 1'b0;
            idx        <= '0;
            settle_cnt <= '0;
`ifdef PUF_MAJORITY_VOTE_EN
            pass_q     <= '0;
            vote_q     <= '0;
`endif
          end
        end
        S_SELECT: begin
          settle_cnt <= settle_end ? '0 : settle_cnt + ST_W'(1);
          race_cnt   <= '0;
        end
        S_RACE: begin
          race_cnt <= race_cnt + TO_W'(1);
          // A tie, B winning and a timeout all resolve to 0.
          bit_q    <= finished_a & ~finished_b;
          if (!pulse && race_end) error <= 1'b1;
        end
        S_RECORD: begin
`ifdef PUF_MAJORITY_VOTE_EN
          if (!last_pass) begin
            pass_q <= pass_q + 2'd1;
            vote_q <= vote_q + {1'b0, bit_q};
          end else begin
            response[idx] <= vote_q[1] | (vote_q[0] & bit_q);
            pass_q        <= '0;
            vote_q        <= '0;
            if (idx != LAST_IDX) idx <= idx + IDX_W'(1);
          end
`else
          response[idx] <= bit_q;
          if (idx != LAST_IDX) idx <= idx + IDX_W'(1);
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_puf_race_controller.sv
// Directed bench for puf_race_controller: a responder plays the race counters from per-bit tables,
// a scoreboard queue holds expected results and a monitor compares them on each done pulse.
module tb_puf_race_controller;
  localparam int RB = 8, SW = 4, ST = 4, TO = 20;
`ifdef PUF_MAJORITY_VOTE_EN
  localparam int PASSES = 3;
`else
  localparam int PASSES = 1;
`endif

  logic clk = 0, rst = 1, start = 0, finished_a = 0, finished_b = 0;
  logic [RB*2*SW-1:0] challenge;
  logic [SW-1:0] sel_a, sel_b;
  logic cnt_reset, cnt_enable, busy, done, error;
  logic [RB-1:0] response;

  puf_race_controller #(.RESP_BITS(RB), .SEL_W(SW), .SETTLE_CYCLES(ST), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(rst), .start(start), .challenge(challenge),
    .finished_a(finished_a), .finished_b(finished_b),
    .sel_a(sel_a), .sel_b(sel_b), .cnt_reset(cnt_reset), .cnt_enable(cnt_enable),
    .busy(busy), .done(done), .response(response), .error(error));

  always #5 clk = ~clk;

  typedef struct { logic [RB-1:0] resp; logic err; int cyc; } exp_t;
  exp_t exp_q[$];

  int checks = 0, passes = 0;
  int da_tab[3][RB], db_tab[3][RB];  // RACE cycle (1-based) of each pulse; 0 = never
  int race_len[RB];
  int sel_entries = 0, done_cnt = 0;
  bit stray = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
  endtask

  task automatic set_all(input int a, input int b);
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < RB; i++) begin da_tab[p][i] = a; db_tab[p][i] = b; end
  endtask

  function automatic int lat();
    int s = 0;
    for (int i = 0; i < RB; i++)
      for (int p = 0; p < PASSES; p++) begin
        int r = TO;
        if (da_tab[p][i] != 0 && da_tab[p][i] < r) r = da_tab[p][i];
        if (db_tab[p][i] != 0 && db_tab[p][i] < r) r = db_tab[p][i];
        s += ST + r + 1;
      end
    return s;
  endfunction

  // Counter model: pulses driven from the tables, indexed by bit (sel_a) and pass.
  initial begin
    int k = 0, rlen = 0, b, p, e;
    logic prev_rst = 0, prev_busy = 0;
    forever begin
      @(posedge clk); #1;
      if (busy && !prev_busy) sel_entries = 0;
      if (cnt_reset && !prev_rst) begin
        sel_entries++;
        e = (sel_entries - 1) / PASSES;
        chk("sel_a_slice", 32'(sel_a), 32'(e));
        chk("sel_b_slice", 32'(sel_b), 32'(15 - e));
        rlen = 0;
      end
      if (cnt_reset) rlen++;
      if (!cnt_reset && prev_rst && !rst) chk("settle_len", rlen, ST);
      if (cnt_enable) begin
        k++;
        b = int'(sel_a) % RB;
        p = (sel_entries - 1) % PASSES;
        finished_a = (da_tab[p][b] == k);
        finished_b = (db_tab[p][b] == k);
        race_len[b] = k;
      end else begin
        k = 0;
        finished_a = 0;
        finished_b = stray;  // stray pulses outside RACE must be ignored
      end
      prev_rst = cnt_reset;
      prev_busy = busy;
    end
  end

  // Scoreboard monitor.
  initial begin
    int busy_cnt = 0;
    logic mprev = 0, last_done = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy && !mprev) busy_cnt = 0;
      if (busy) busy_cnt++;
      if (last_done) chk("done_one_cycle", done, 0);
      if (done) begin
        done_cnt++;
        chk("busy_low_at_done", busy, 0);
        if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("response", response, e.resp);
          chk("error", error, e.err);
          chk("latency", busy_cnt, e.cyc);
          chk("select_passes", sel_entries, RB * PASSES);
        end
      end
      last_done = done;
      mprev = busy;
    end
  end

  task automatic run(input logic [RB-1:0] r, input logic e, input bit hold, input bit repulse);
    int n = 0;
    exp_q.push_back('{resp: r, err: e, cyc: lat()});
    start = 1;
    @(posedge clk); #2;
    chk("busy_after_start", busy, 1);
    chk("error_cleared", error, 0);
    chk("response_cleared", response, 0);
    if (!hold) start = 0;
    while (!done && n < 4000) begin
      @(posedge clk); #2; n++;
      if (repulse && n == 20) start = 1;
      else if (repulse && n == 21 && !hold) start = 0;
    end
    chk("done_seen", done, 1);
    start = 0;
    repeat (6) @(posedge clk); #2;
    chk("idle_no_rerun", busy, 0);
    chk("response_hold", response, r);
    chk("error_hold", error, e);
  endtask

  initial begin
    int n;
    int d0;
    for (int i = 0; i < RB; i++) begin
      challenge[2*i*SW +: SW] = SW'(i);
      challenge[(2*i+1)*SW +: SW] = SW'(15 - i);
    end
    set_all(10, 0);
    #1;
    chk("reset_outputs", {busy, done, error, cnt_reset, cnt_enable, sel_a, sel_b, response}, 0);
    @(posedge clk); #2; rst = 0;
    @(posedge clk); #2;
    chk("idle_outputs", {busy, done, error, cnt_reset, cnt_enable, sel_a, sel_b, response}, 0);

    // basic: A wins 10 cycles in, stray B outside RACE
    stray = 1; set_all(10, 0);
    run(8'hFF, 0, 0, 0);
    stray = 0;

    // alternating winner
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < RB; i++) begin
        da_tab[p][i] = (i % 2) ? 5 : 0;
        db_tab[p][i] = (i % 2) ? 0 : 5;
      end
    run(8'hAA, 0, 0, 0);

    // tie on bit 2, timeout on bit 5
    set_all(10, 0);
    for (int p = 0; p < 3; p++) begin
      db_tab[p][2] = 10;
      da_tab[p][5] = 0;
    end
    run(8'hDB, 1, 0, 0);
    chk("timeout_race_len", race_len[5], TO);

    // start held high and re-pulsed while busy; new start clears error
    set_all(7, 0);
    run(8'hFF, 0, 1, 1);

    // majority-style pass pattern (single pass uses pass 0 only)
    set_all(6, 0);
    da_tab[0][0] = 6; db_tab[0][0] = 0;
    da_tab[1][0] = 0; db_tab[1][0] = 6;
    da_tab[2][0] = 6; db_tab[2][0] = 0;
    da_tab[0][1] = 0; db_tab[0][1] = 6;
    da_tab[1][1] = 0; db_tab[1][1] = 6;
    da_tab[2][1] = 6; db_tab[2][1] = 0;
    run(8'hFD, 0, 0, 0);

    // async reset in RACE of bit 3
    set_all(10, 0);
    d0 = done_cnt;
    start = 1;
    @(posedge clk); #2; start = 0;
    n = 0;
    while (!(cnt_enable && sel_a == 3) && n < 2000) begin @(posedge clk); #2; n++; end
    chk("reached_bit3_race", {cnt_enable, sel_a}, {1'b1, 4'd3});
    #2; rst = 1; #1;
    chk("async_reset_outputs", {busy, done, error, cnt_reset, cnt_enable, sel_a, sel_b, response}, 0);
    repeat (3) @(posedge clk); #2; rst = 0;
    repeat (4) @(posedge clk); #2;
    chk("no_done_after_reset", done_cnt - d0, 0);
    run(8'hFF, 0, 0, 0);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/puf_race_controller.md
Name: puf_race_controller

Overview:
- Sequences one delay-PUF evaluation of RESP_BITS response bits.
- For each bit it drives the oscillator mux selects, then holds the shared race counters in reset for a settle window.
- It then enables both counters and records which counter reaches its goal first.
- Sits between the challenge/response host interface and the two post-mux race counters; their one-cycle finished pulses (already synchronised to clk) come back as finished_a and finished_b.

Parameters:
- RESP_BITS, 8, response bits per challenge.
- SEL_W, 4, width of each oscillator mux select.
- SETTLE_CYCLES, 4, cycles the counters are held in reset after a select change (minimum 1).
- TIMEOUT, 1023, maximum race cycles per bit before abort.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-high reset.
- start, input, 1, begin an evaluation; honoured only in IDLE.
- challenge, input, RESP_BITS*2*SEL_W, selects; bit i uses sel_a = challenge[2i*SEL_W +: SEL_W] and sel_b = challenge[(2i+1)*SEL_W +: SEL_W]; latched on accepted start.
- finished_a, input, 1, goal pulse from counter A.
- finished_b, input, 1, goal pulse from counter B.
- sel_a, output, SEL_W, mux select for oscillator A.
- sel_b, output, SEL_W, mux select for oscillator B.
- cnt_reset, output, 1, synchronous reset to both race counters.
- cnt_enable, output, 1, count enable to both race counters.
- busy, output, 1, high from the cycle after start until done.
- done, output, 1, one-cycle pulse when response is valid.
- response, output, RESP_BITS, response bits; response[i] is bit i.
- error, output, 1, one or more bits timed out during the last evaluation.

Behaviour:
- Clock/reset: one clock, clk. reset is asynchronous and active-high and forces IDLE. On reset all outputs are 0, including sel_a, sel_b, response and error; the latched challenge, bit index and timers also clear.
- FSM states: IDLE, SELECT, RACE, RECORD, DONE.
- IDLE:
  - start=1 latches challenge, clears response and error, sets bit index to 0, and goes to SELECT.
  - start in any other state is ignored.
- SELECT:
  - sel_a/sel_b driven from the latched challenge for the current index.
  - cnt_reset=1, cnt_enable=0.
  - Stays exactly SETTLE_CYCLES cycles, then goes to RACE.
- RACE:
  - cnt_reset=0, cnt_enable=1; finished_a/finished_b sampled every cycle.
  - finished_a=1 and finished_b=0: bit=1.
  - finished_b=1 and finished_a=0: bit=0.
  - Both high in the same cycle: tie, bit=0.
  - Exit to RECORD on the first cycle either input is seen.
  - Race timer counts RACE cycles. If it reaches TIMEOUT with no pulse: bit=0, error set (sticky until next start), go to RECORD.
  - Pulses are single-cycle and are never missed, because sampling occurs every RACE cycle.
- RECORD:
  - cnt_enable=0; response[index] written.
  - If index == RESP_BITS-1, go to DONE; else increment index and go to SELECT.
- DONE: done=1 for one cycle, busy=0, then IDLE. response and error hold until the next accepted start or reset.
- Latency per bit: SETTLE_CYCLES + race cycles + 1.
- busy: 1 in SELECT, RACE and RECORD.
- Ignored inputs: finished pulses outside RACE are ignored.
- Mid-evaluation reset: aborts immediately; no done pulse is produced.

Optional Feature:
- Macro: PUF_MAJORITY_VOTE_EN.
- Defined:
  - Each bit runs three SELECT/RACE passes, with counters re-reset each pass.
  - A 2-bit vote counter accumulates the pass results; response[i] = 1 when 2 or more passes gave 1.
  - Any pass timeout sets error.
  - Per-bit latency is roughly tripled.
- Undefined: single pass per bit, exactly as above.

Test Plan:
- Basic race: RESP_BITS=8, SETTLE_CYCLES=4; finished_a pulses 10 cycles into every RACE -> done after 8*(4+10+1) cycles; response=8'hFF; error=0.
- Alternating winner: finished_b wins on even bits, finished_a on odd bits -> response=8'hAA; sel_a/sel_b match the challenge slices each SELECT.
- Tie and timeout: bit 2 gets simultaneous pulses, bit 5 gets no pulse with TIMEOUT=20; all other bits A wins -> response=8'hDB; error=1; bit 5 RACE lasts exactly 20 cycles.
- Handshake: start held high throughout and re-pulsed while busy -> exactly one evaluation; done one cycle; next evaluation starts only after IDLE; new start clears error.
- Async reset mid-RACE (bit 3) -> outputs 0 without waiting for a clk edge; no done pulse; following start runs a full 8-bit evaluation.
- PUF_MAJORITY_VOTE_EN: bit 0 passes give A, B, A -> response[0]=1; passes give B, B, A -> 0; cnt_reset asserted for SETTLE_CYCLES before each of the 3 passes.
